// File: rtl/regfile_sequencer.sv
// regfile_sequencer: bus master for the 8x16 register file.
// Accepts one transfer request, reads its sources through the file's single
// combinational read port, computes, writes one result back and pulses done.
module regfile_sequencer #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   opcode,
    input  logic [2:0]   rd,
    input  logic [2:0]   rs,
    input  logic [2:0]   rt,
    input  logic [n-1:0] imm,
    output logic [2:0]   rf_readnum,
    input  logic [n-1:0] rf_data_out,
    output logic [2:0]   rf_writenum,
    output logic         rf_write,
    output logic [n-1:0] rf_data_in,
    output logic         done,
    output logic [n-1:0] result
);

    typedef enum logic [2:0] {
        IDLE,
        READ_A,
        READ_B,
        EXEC,
        WRITE,
        DONE
    } state_t;

    localparam logic [1:0] OP_MOVI = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b11;

    state_t         state;
    state_t         state_next;
    logic           accept;
    logic [1:0]     op_q;
    logic [2:0]     rd_q;
    logic [2:0]     rs_q;
    logic [2:0]     rt_q;
    logic [n-1:0]   a_q;
    logic [n-1:0]   b_q;
    logic [n-1:0]   result_q;

    // Next-state and handshake/bus outputs; everything is masked while reset is high
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rf_write   = 1'b0;
        done       = 1'b0;
        rf_readnum = rs_q;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~reset;
                accept    = req_valid & ~reset;
                if (accept)
                    state_next = (opcode == OP_MOVI) ? WRITE : READ_A;
            end
            READ_A:  state_next = (op_q == OP_MOV) ? WRITE : READ_B;
            READ_B: begin
                rf_readnum = rt_q;
                state_next = EXEC;
            end
            EXEC:    state_next = WRITE;
            WRITE: begin
                rf_write   = ~reset;
                state_next = DONE;
            end
            DONE: begin
                done       = ~reset;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Request latch, operand capture and result computation
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= opcode;
                        rd_q <= rd;
                        rs_q <= rs;
                        rt_q <= rt;
                        if (opcode == OP_MOVI)
                            result_q <= imm;
                    end
                end
                READ_A: begin
                    a_q <= rf_data_out;
                    if (op_q == OP_MOV)
                        result_q <= rf_data_out;
                end
                READ_B:  b_q <= rf_data_out;
                EXEC:    result_q <= (op_q == OP_SUB) ? (a_q - b_q) : (a_q + b_q);
                default: ;
            endcase
        end
    end

    assign rf_writenum = rd_q;
    assign rf_data_in  = result_q;
    assign result      = result_q;

endmodule
